// File: rtl/frv_mask_pkg.sv
// Shared definitions for the masking-ISE randomness source.
package frv_mask_pkg;

    localparam logic [31:0] LFSR_TAPS     = 32'h80200003;
    localparam logic [31:0] RESET_SEED    = 32'h6789ABCD;
    localparam int          RESEED_PERIOD = 1024;
    localparam int          STARVE_LIMIT  = 2048;

    // SEED: waiting for entropy, RUN: serving masks, REFRESH: serving and asking for entropy
    typedef enum logic [1:0] {
        SEED    = 2'd0,
        RUN     = 2'd1,
        REFRESH = 2'd2
    } state_t;

    // One Galois LFSR shift; shared with the formal models that predict mask words
    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/frv_mask_lfsr_step.sv
// Combinational Galois LFSR step followed by the all-zero escape.
module frv_mask_lfsr_step #(
    parameter int          XL         = 31,
    parameter logic [XL:0] LFSR_TAPS  = 32'h80200003,
    parameter logic [XL:0] RESET_SEED = 32'h6789ABCD
) (
    input  logic [XL:0] din,
    output logic [XL:0] dout
);

    logic [XL:0] stepped;

    // Shift right and fold the taps in when the bit shifted out was set; an all-zero
    // result would lock the LFSR, so it is replaced by the reset seed.
    always_comb begin
        stepped = (din >> 1) ^ (din[0] ? LFSR_TAPS : '0);
        dout    = (stepped == '0) ? RESET_SEED : stepped;
    end

endmodule

// File: rtl/frv_mask_rng.sv
// Mask-randomness source: LFSR mask words over valid/ready, re-keyed from entropy.
module frv_mask_rng
    import frv_mask_pkg::state_t, frv_mask_pkg::SEED, frv_mask_pkg::RUN, frv_mask_pkg::REFRESH;
#(
    parameter int          XL            = 31,
    parameter logic [XL:0] LFSR_TAPS     = frv_mask_pkg::LFSR_TAPS,
    parameter logic [XL:0] RESET_SEED    = frv_mask_pkg::RESET_SEED,
    parameter int          RESEED_PERIOD = frv_mask_pkg::RESEED_PERIOD,
    parameter int          STARVE_LIMIT  = frv_mask_pkg::STARVE_LIMIT
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        ent_valid,
    input  logic [XL:0] ent_data,
    output logic        ent_ready,
    input  logic        msk_ready,
    output logic        msk_valid,
    output logic [XL:0] msk_data,
    output logic        reseed_req
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [XL:0]   lfsr;
    logic [XL:0]   step_in;
    logic [XL:0]   step_out;
    logic [CW-1:0] use_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          load;
    logic          msk_fire;
    logic          ent_fire;

    frv_mask_lfsr_step #(
        .XL         (XL),
        .LFSR_TAPS  (LFSR_TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_step (
        .din  (step_in),
        .dout (step_out)
    );

    // Outputs depend only on registered state so consumers see no combinational loop
    always_comb begin
        msk_valid  = (state == RUN) || (state == REFRESH);
        ent_ready  = (state == SEED) || (state == REFRESH);
        reseed_req = ent_ready;
        msk_data   = msk_valid ? lfsr : '0;
        msk_fire   = msk_valid & msk_ready;
        ent_fire   = ent_valid & ent_ready;
        cnt_inc    = (use_cnt == CW'(STARVE_LIMIT)) ? use_cnt : use_cnt + 1'b1;
    end

    // Next-state logic: pick the step input and decide whether the LFSR advances this cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = use_cnt;
        step_in   = lfsr;
        load      = 1'b0;
        case (state)
            SEED: begin
                step_in = ent_data;
                if (ent_fire) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (msk_fire) begin
                    load    = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (use_cnt == CW'(RESEED_PERIOD - 1)) begin
                        state_nxt = REFRESH;
                    end
                end
            end
            REFRESH: begin
                if (ent_fire) begin
                    step_in   = lfsr ^ ent_data;
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end else if (msk_fire) begin
                    load    = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (use_cnt == CW'(STARVE_LIMIT - 1)) begin
                        state_nxt = SEED;
                    end
                end
            end
            default: begin
                state_nxt = SEED;
            end
        endcase
    end

    // State, LFSR and usage counter registers
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state   <= SEED;
            lfsr    <= RESET_SEED;
            use_cnt <= '0;
        end else begin
            state   <= state_nxt;
            use_cnt <= cnt_nxt;
            if (load) begin
                lfsr <= step_out;
            end
        end
    end

endmodule
